// File: rtl/lsu.sv
// Load/store unit: one memory transaction per instruction, with byte/half/word lane
// steering, load extension and misaligned/illegal/timeout fault reporting.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wen_q, wen_d;
    logic [2:0]       f3_q, f3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic        illegal, misaligned;
    logic [31:0] sh, load_ext;

    // Unsigned variants (1xx) have no store form, so a store with them is illegal too.
    assign illegal    = (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11) ||
                        (in_funct3[2] && in_wen);
    assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                        ((in_funct3 == 3'b010) && (in_addr[1:0] != 2'b00));

    assign sh = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = mem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_ext = {24'b0, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_ext = {16'b0, sh[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == RESP);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q << {addr_q[1:0], 3'b000};

    always_comb begin
        mem_wmask = 4'b0000;
        if (wen_q) begin
            case (f3_q[1:0])
                2'b00:   mem_wmask = 4'b0001 << addr_q[1:0];
                2'b01:   mem_wmask = 4'b0011 << addr_q[1:0];
                default: mem_wmask = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    wen_d   = in_wen;
                    f3_d    = in_funct3;
                    if (illegal || misaligned) begin
                        rdata_d = 32'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = wen_q ? 32'b0 : load_ext;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            f3_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected completions are queued at issue and retired on out_valid.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_wen = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    lsu #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_wen(in_wen), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Completion monitor
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_rdata", out_rdata, e.rd);
                chk("out_err", {31'b0, out_err}, {31'b0, e.err});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [2:0] f3, input int rdly, input bit resp,
                          input logic [31:0] mrd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat, input bit exp_req,
                          input logic [31:0] exp_wd, input logic [3:0] exp_msk);
        int  reqc = 0;
        bit  hs = 0, sent = 0, done = 0, sawreq = 0;
        exp_t e;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_addr = a; in_wdata = wd; in_wen = we; in_funct3 = f3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.rd = exp_rd; e.err = exp_err; e.cyc = cyc + exp_lat - 1;
        sb.push_back(e);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (hs && resp && !sent) begin
                mem_resp_valid = 1'b1;
                mem_rdata = mrd;
                sent = 1;
            end
            mem_req_ready = (reqc >= rdly);
            if (mem_req_valid) begin
                sawreq = 1;
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_wen", {31'b0, mem_wen}, {31'b0, we});
                chk("mem_wdata", mem_wdata, exp_wd);
                chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, exp_msk});
                if (mem_req_ready) hs = 1;
                reqc++;
            end
            if (out_valid) done = 1;
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        chk("completed", {31'b0, done}, 32'd1);
        chk("req_issued", {31'b0, sawreq}, {31'b0, exp_req});
        @(negedge clk);
        chk("single_pulse", {31'b0, out_valid}, 32'd0);
        chk("rdata_hold", out_rdata, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
        chk("rst_wmask", {28'b0, mem_wmask}, 32'd0);
        rst = 1'b0;

        // Word load, ready high, response one cycle after handshake
        run_op(32'h80000004, 32'h0, 1'b0, 3'b010, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3, 1, 32'h0, 4'b0000);
        // Load extraction
        run_op(32'h80000003, 32'h0, 1'b0, 3'b000, 0, 1, 32'h80112233, 32'hFFFFFF80, 1'b0, 3, 1, 32'h0, 4'b0000);
        run_op(32'h80000003, 32'h0, 1'b0, 3'b100, 0, 1, 32'h80112233, 32'h00000080, 1'b0, 3, 1, 32'h0, 4'b0000);
        run_op(32'h80000002, 32'h0, 1'b0, 3'b001, 0, 1, 32'h80112233, 32'hFFFF8011, 1'b0, 3, 1, 32'h0, 4'b0000);
        run_op(32'h80000000, 32'h0, 1'b0, 3'b101, 0, 1, 32'h80112233, 32'h00002233, 1'b0, 3, 1, 32'h0, 4'b0000);
        run_op(32'h80000001, 32'h0, 1'b0, 3'b000, 0, 1, 32'h80112233, 32'h00000022, 1'b0, 3, 1, 32'h0, 4'b0000);
        // Stores: lanes and strobes, rdata forced to 0
        run_op(32'h80000001, 32'h000000AB, 1'b1, 3'b000, 0, 1, 32'hFFFFFFFF, 32'h0, 1'b0, 3, 1, 32'h0000AB00, 4'b0010);
        run_op(32'h80000002, 32'h00001234, 1'b1, 3'b001, 0, 1, 32'hFFFFFFFF, 32'h0, 1'b0, 3, 1, 32'h12340000, 4'b1100);
        run_op(32'h00000010, 32'hCAFEF00D, 1'b1, 3'b010, 0, 1, 32'hFFFFFFFF, 32'h0, 1'b0, 3, 1, 32'hCAFEF00D, 4'b1111);
        // Faults detected at accept: no memory request
        run_op(32'h80000002, 32'h0, 1'b0, 3'b010, 0, 1, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000);
        run_op(32'h80000001, 32'h00001234, 1'b1, 3'b001, 0, 1, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000);
        run_op(32'h80000000, 32'h0, 1'b0, 3'b011, 0, 1, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000);
        run_op(32'h80000000, 32'h0, 1'b0, 3'b110, 0, 1, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000);
        // Back-pressured request, then timeout with no response
        run_op(32'h00000104, 32'h0, 1'b0, 3'b010, 5, 1, 32'h13579BDF, 32'h13579BDF, 1'b0, 8, 1, 32'h0, 4'b0000);
        run_op(32'h00000200, 32'h0, 1'b0, 3'b010, 0, 0, 32'h0, 32'h0, 1'b1, 10, 1, 32'h0, 4'b0000);

        // Reset in the middle of WAIT, then a late response
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h00000300; in_wen = 1'b0; in_funct3 = 3'b010; in_wdata = '0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("wait_in_ready", {31'b0, in_ready}, 32'd0);
        chk("wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_rdata", out_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hBADBAD00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            chk("late_resp_out_valid", {31'b0, out_valid}, 32'd0);
            chk("late_resp_in_ready", {31'b0, in_ready}, 32'd1);
        end
        run_op(32'h00000408, 32'h0, 1'b0, 3'b010, 0, 1, 32'h01234567, 32'h01234567, 1'b0, 3, 1, 32'h0, 4'b0000);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
